ex_stage: RTL
=============

# ex_stage

Execute stage of the CPU pipeline: takes decoded operands and control from the ID/EX boundary, computes the result through the ALU, and registers the result and control into the EX/MEM pipeline register. An arithmetic overflow on a signed operation becomes an overflow exception: the faulting instruction's register write and memory access are suppressed, and the exception code travels down the pipeline to the control unit.

## Interface
Parameters:
- none; all widths come from the shared CPU header (`WordDataBus` 32, `WordAddrBus` 30, `AluOpBus` 4, `MemOpBus` 2, `CtrlOpBus` 2, `RegAddrBus` 5, `IsaExpBus` 3).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low.
- stall  in  1  hold the EX/MEM register.
- flush  in  1  replace the registered instruction with a bubble.
- id_pc  in  30  PC of the incoming instruction.
- id_en  in  1  incoming instruction valid.
- id_alu_op  in  4  ALU operation.
- id_alu_in_0, id_alu_in_1  in  32  ALU operands.
- id_br_flag  in  1  branch-taken flag.
- id_mem_op  in  2  memory op.
- id_mem_wr_data  in  32  store data.
- id_ctrl_op  in  2  control op.
- id_dst_addr  in  5  destination GPR.
- id_gpr_we_  in  1  GPR write enable, active-low.
- id_exp_code  in  3  exception code from earlier stages.
- ex_fwd_data  out  32  combinational ALU result for the ID forwarding path (see Configuration).
- ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code  out  match input widths  registered copies.
- ex_out  out  32  registered ALU result.

## Operation
- The ALU is combinational on `id_alu_in_0`, `id_alu_in_1` and `id_alu_op`, and produces the result `alu_out` and the overflow flag `alu_of`.
- Overflow condition `ovf = id_en & alu_of`. `alu_of` can only be set by `ALU_OP_ADDS` and `ALU_OP_SUBS`. The unsigned ops `ADDU` and `SUBU` never raise it.
- Register update priority, highest first: reset, stall, flush, normal load.
  - **Reset (reset=0):** `ex_pc=0`, `ex_en=DISABLE`, `ex_br_flag=DISABLE`, `ex_mem_op=MEM_OP_NOP`, `ex_mem_wr_data=0`, `ex_ctrl_op=CTRL_OP_NOP`, `ex_dst_addr=0`, `ex_gpr_we_=DISABLE_`, `ex_exp_code=ISA_EXP_NO_EXP`, `ex_out=0`. The reset takes effect immediately, even mid-instruction.
  - **stall=1:** every register holds its value. This applies even if flush=1 in the same cycle. The flush is not lost, because the control unit keeps flush asserted until the stall drops.
  - **flush=1, stall=0:** load the same values as reset, except `ex_pc` loads `id_pc`.
  - **Normal load:** all fields copy their id_* inputs, and `ex_out` loads `alu_out`.
  - **Overflow override:** if `ovf` is set during a normal load, then `ex_mem_op=MEM_OP_NOP`, `ex_gpr_we_=DISABLE_` and `ex_exp_code=ISA_EXP_OVERFLOW`. `ex_out` still captures the wrapped sum/difference, for debug.
  - If `id_exp_code` is not `NO_EXP` and `ovf`=0, `ex_exp_code` passes the incoming code through unchanged. If both are present, `OVERFLOW` wins: an upstream exception means the instruction is already invalid upstream, so that combination does not occur in legal traffic.
- When `id_en`=0, all fields still copy their inputs, and the overflow override is inhibited.

## Timing
- Latency is one cycle from id_* inputs to ex_* outputs.
- `ex_fwd_data` has zero latency, combinational from the id_* inputs.
- Stall, flush and `ovf` are all sampled at the same rising edge as the data.
- There is no handshake; flow control is entirely through stall and flush.

## Configuration
- `EX_FWD_EN` defined: `ex_fwd_data = alu_out`, combinationally.
- `EX_FWD_EN` undefined: `ex_fwd_data` is tied to 0. The port remains so the top level is unchanged, and the ID stage must then resolve EX-stage hazards by stalling.

## Structure
- The shared CPU header holds:
  - `ALU_OP_*`, `MEM_OP_*`, `CTRL_OP_*` and `ISA_EXP_*` codes;
  - the bus widths;
  - `ENABLE`/`DISABLE`, `ENABLE_`/`DISABLE_`.
  - This block defines no new constants.
- Sub-module: one instance of the existing `alu`.
- Natural split: the ALU instance, and the EX/MEM register process in this module.

## Test plan
- **Signed add overflow:** ADDS, 0x7FFFFFFF + 0x00000001, id_en=1, id_gpr_we_=0, id_mem_op=store → next cycle:
  - `ex_out=0x80000000`, `ex_exp_code=ISA_EXP_OVERFLOW`;
  - `ex_gpr_we_=1`, `ex_mem_op=MEM_OP_NOP`.
- **Unsigned add, same operands:** ADDU, 0x7FFFFFFF + 0x00000001 → `ex_out=0x80000000`, `ex_exp_code=NO_EXP`, `ex_gpr_we_=0`.
- **Signed subtract overflow, and no overflow when invalid:** SUBS, 0x80000000 − 0x00000001 → `OVERFLOW`. The same with id_en=0 → `NO_EXP`, `ex_en=0`.
- **Stall and flush:** load AND 0xF0F0F0F0 & 0x0FF00FF0 (`ex_out=0x00F000F0`).
  - Stall for 3 cycles while the inputs change → outputs hold.
  - Assert stall and flush together → outputs still hold.
  - Then flush alone → `ex_en=0`, `ex_gpr_we_=1`, `ex_pc=id_pc`.
- **Reset mid-operation:** drop reset between clock edges while `ex_out=0x12345678` → all outputs reach reset values immediately, without waiting for clk.
- **Forwarding (EX_FWD_EN defined):** SHLL 0x00000001 by 4 → `ex_fwd_data=0x00000010` in the same cycle, and `ex_out=0x10` after the edge. Without the macro, `ex_fwd_data=0`.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared CPU definitions for the execute stage: bus widths, op codes, exception codes,
// polarity constants and the EX/MEM pipeline register layout.
package ex_stage_pkg;

   localparam int WORD_DATA_W = 32;
   localparam int WORD_ADDR_W = 30;
   localparam int ALU_OP_W    = 4;
   localparam int MEM_OP_W    = 2;
   localparam int CTRL_OP_W   = 2;
   localparam int REG_ADDR_W  = 5;
   localparam int ISA_EXP_W   = 3;

   localparam logic ENABLE   = 1'b1;
   localparam logic DISABLE  = 1'b0;
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_OP_NOP  = 4'd0,
      ALU_OP_AND  = 4'd1,
      ALU_OP_OR   = 4'd2,
      ALU_OP_XOR  = 4'd3,
      ALU_OP_ADDS = 4'd4,
      ALU_OP_ADDU = 4'd5,
      ALU_OP_SUBS = 4'd6,
      ALU_OP_SUBU = 4'd7,
      ALU_OP_SHRL = 4'd8,
      ALU_OP_SHLL = 4'd9
   } alu_op_e;

   typedef enum logic [MEM_OP_W-1:0] {
      MEM_OP_NOP = 2'd0,
      MEM_OP_LDW = 2'd1,
      MEM_OP_STW = 2'd2
   } mem_op_e;

   typedef enum logic [CTRL_OP_W-1:0] {
      CTRL_OP_NOP  = 2'd0,
      CTRL_OP_WRCR = 2'd1,
      CTRL_OP_EXRT = 2'd2
   } ctrl_op_e;

   typedef enum logic [ISA_EXP_W-1:0] {
      ISA_EXP_NO_EXP     = 3'd0,
      ISA_EXP_EXT_INT    = 3'd1,
      ISA_EXP_UNDEF_INSN = 3'd2,
      ISA_EXP_OVERFLOW   = 3'd3,
      ISA_EXP_MISS_ALIGN = 3'd4,
      ISA_EXP_TRAP       = 3'd5,
      ISA_EXP_PRV_VIO    = 3'd6
   } isa_exp_e;

   typedef struct packed {
      logic [WORD_ADDR_W-1:0] pc;
      logic                   en;
      logic                   br_flag;
      logic [MEM_OP_W-1:0]    mem_op;
      logic [WORD_DATA_W-1:0] mem_wr_data;
      logic [CTRL_OP_W-1:0]   ctrl_op;
      logic [REG_ADDR_W-1:0]  dst_addr;
      logic                   gpr_we_;
      logic [ISA_EXP_W-1:0]   exp_code;
      logic [WORD_DATA_W-1:0] out;
   } ex_mem_t;

   localparam ex_mem_t EX_MEM_RST = '{
      pc:          30'h0,
      en:          DISABLE,
      br_flag:     DISABLE,
      mem_op:      MEM_OP_NOP,
      mem_wr_data: 32'h0,
      ctrl_op:     CTRL_OP_NOP,
      dst_addr:    5'h0,
      gpr_we_:     DISABLE_,
      exp_code:    ISA_EXP_NO_EXP,
      out:         32'h0
   };

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU; only the signed add/subtract ops can flag overflow.
module ex_stage_alu
   import ex_stage_pkg::*;
(
   input  logic [WORD_DATA_W-1:0] in_0,
   input  logic [WORD_DATA_W-1:0] in_1,
   input  logic [ALU_OP_W-1:0]    op,
   output logic [WORD_DATA_W-1:0] out,
   output logic                   of
);

   // Overflow: operands agree in sign but the result's sign differs (subtract flips in_1).
   always_comb begin
      out = 32'h0;
      of  = 1'b0;
      case (op)
         ALU_OP_AND:  out = in_0 & in_1;
         ALU_OP_OR:   out = in_0 | in_1;
         ALU_OP_XOR:  out = in_0 ^ in_1;
         ALU_OP_ADDS: begin
            out = in_0 + in_1;
            of  = (in_0[31] == in_1[31]) && (out[31] != in_0[31]);
         end
         ALU_OP_ADDU: out = in_0 + in_1;
         ALU_OP_SUBS: begin
            out = in_0 - in_1;
            of  = (in_0[31] != in_1[31]) && (out[31] != in_0[31]);
         end
         ALU_OP_SUBU: out = in_0 - in_1;
         ALU_OP_SHRL: out = in_0 >> in_1[4:0];
         ALU_OP_SHLL: out = in_0 << in_1[4:0];
         default: begin
            out = 32'h0;
            of  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU plus the EX/MEM pipeline register with overflow exception insertion.
// Define EX_FWD_EN to drive ex_fwd_data from the ALU; otherwise it is tied to zero.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   flush,
   input  logic [WORD_ADDR_W-1:0] id_pc,
   input  logic                   id_en,
   input  logic [ALU_OP_W-1:0]    id_alu_op,
   input  logic [WORD_DATA_W-1:0] id_alu_in_0,
   input  logic [WORD_DATA_W-1:0] id_alu_in_1,
   input  logic                   id_br_flag,
   input  logic [MEM_OP_W-1:0]    id_mem_op,
   input  logic [WORD_DATA_W-1:0] id_mem_wr_data,
   input  logic [CTRL_OP_W-1:0]   id_ctrl_op,
   input  logic [REG_ADDR_W-1:0]  id_dst_addr,
   input  logic                   id_gpr_we_,
   input  logic [ISA_EXP_W-1:0]   id_exp_code,
   output logic [WORD_DATA_W-1:0] ex_fwd_data,
   output logic [WORD_ADDR_W-1:0] ex_pc,
   output logic                   ex_en,
   output logic                   ex_br_flag,
   output logic [MEM_OP_W-1:0]    ex_mem_op,
   output logic [WORD_DATA_W-1:0] ex_mem_wr_data,
   output logic [CTRL_OP_W-1:0]   ex_ctrl_op,
   output logic [REG_ADDR_W-1:0]  ex_dst_addr,
   output logic                   ex_gpr_we_,
   output logic [ISA_EXP_W-1:0]   ex_exp_code,
   output logic [WORD_DATA_W-1:0] ex_out
);

   logic [WORD_DATA_W-1:0] alu_out;
   logic                   alu_of;
   logic                   ovf;
   ex_mem_t                ex_mem_d;
   ex_mem_t                ex_mem_q;

   ex_stage_alu u_alu (
      .in_0 (id_alu_in_0),
      .in_1 (id_alu_in_1),
      .op   (id_alu_op),
      .out  (alu_out),
      .of   (alu_of)
   );

   assign ovf = id_en & alu_of;

`ifdef EX_FWD_EN
   assign ex_fwd_data = alu_out;
`else
   assign ex_fwd_data = 32'h0;
`endif

   // Next EX/MEM contents: stall holds (even over flush), flush inserts a bubble keeping the PC.
   always_comb begin
      ex_mem_d = ex_mem_q;
      if (stall) begin
         ex_mem_d = ex_mem_q;
      end else if (flush) begin
         ex_mem_d    = EX_MEM_RST;
         ex_mem_d.pc = id_pc;
      end else begin
         ex_mem_d.pc          = id_pc;
         ex_mem_d.en          = id_en;
         ex_mem_d.br_flag     = id_br_flag;
         ex_mem_d.mem_op      = id_mem_op;
         ex_mem_d.mem_wr_data = id_mem_wr_data;
         ex_mem_d.ctrl_op     = id_ctrl_op;
         ex_mem_d.dst_addr    = id_dst_addr;
         ex_mem_d.gpr_we_     = id_gpr_we_;
         ex_mem_d.exp_code    = id_exp_code;
         ex_mem_d.out         = alu_out;
         // The wrapped result is still captured so the faulting value is visible for debug.
         if (ovf) begin
            ex_mem_d.mem_op   = MEM_OP_NOP;
            ex_mem_d.gpr_we_  = DISABLE_;
            ex_mem_d.exp_code = ISA_EXP_OVERFLOW;
         end else begin
            ex_mem_d.exp_code = id_exp_code;
         end
      end
   end

   // EX/MEM pipeline register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_mem_q <= EX_MEM_RST;
      end else begin
         ex_mem_q <= ex_mem_d;
      end
   end

   assign ex_pc          = ex_mem_q.pc;
   assign ex_en          = ex_mem_q.en;
   assign ex_br_flag     = ex_mem_q.br_flag;
   assign ex_mem_op      = ex_mem_q.mem_op;
   assign ex_mem_wr_data = ex_mem_q.mem_wr_data;
   assign ex_ctrl_op     = ex_mem_q.ctrl_op;
   assign ex_dst_addr    = ex_mem_q.dst_addr;
   assign ex_gpr_we_     = ex_mem_q.gpr_we_;
   assign ex_exp_code    = ex_mem_q.exp_code;
   assign ex_out         = ex_mem_q.out;

endmodule
